// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the run-control sequencer: state encoding,
// button index map and default parameter values.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BURST  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int COUNT_W_DEF         = 8;

  localparam int BTN_RUN   = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_STEP  = 2;
  localparam int BTN_BURST = 3;
  localparam int NUM_BTNS  = 4;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, run-length debouncer and registered rising-edge
// event for one raw front-panel button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic ev_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the accepted level restarts qualification.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign ev_o = rise_q;

endmodule

// File: rtl/clock_sequencer.sv
// Run-control FSM driving the clock module: free-run, single step,
// N-cycle burst and HLT handling from conditioned front-panel buttons.
module clock_sequencer
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_W         = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_btn,
  input  logic               stop_btn,
  input  logic               step_btn,
  input  logic               burst_btn,
  input  logic [COUNT_W-1:0] burst_n,
  input  logic               hlt_instr,
  output logic               manual_en,
  output logic               adv_clk,
  output logic               halt,
  output logic [1:0]         state,
  output logic [COUNT_W-1:0] cycles_left
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_ev;

  assign btn_raw = {burst_btn, step_btn, stop_btn, run_btn};

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn_i(btn_raw[gi]),
      .ev_o (btn_ev[gi])
    );
  end

  logic run_ev, stop_ev, step_ev, burst_ev;
  assign run_ev   = btn_ev[BTN_RUN];
  assign stop_ev  = btn_ev[BTN_STOP];
  assign step_ev  = btn_ev[BTN_STEP];
  assign burst_ev = btn_ev[BTN_BURST];

  seq_state_e         state_q, state_d;
  logic               adv_q, adv_d;
  logic               men_q, men_d;
  logic               halt_q, halt_d;
  logic [COUNT_W-1:0] left_q, left_d;

  always_comb begin
    state_d = state_q;
    adv_d   = 1'b0;
    left_d  = '0;
    case (state_q)
      ST_IDLE: begin
        // A stop event outranks run/burst/step even though it is a no-op here.
        if (hlt_instr) begin
          state_d = ST_HALTED;
        end else if (!stop_ev) begin
          if (run_ev) begin
            state_d = ST_RUN;
          end else if (burst_ev) begin
            if (burst_n != '0) begin
              state_d = ST_BURST;
              left_d  = burst_n;
              adv_d   = 1'b1;
            end
          end else if (step_ev) begin
            adv_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (hlt_instr) begin
          state_d = ST_HALTED;
        end else if (stop_ev) begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (hlt_instr) begin
          state_d = ST_HALTED;
        end else if (stop_ev) begin
          state_d = ST_IDLE;
        end else if (adv_q) begin
          left_d = left_q - COUNT_W'(1);
        end else if (left_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          left_d = left_q;
          adv_d  = 1'b1;
        end
      end
      ST_HALTED: begin
        // A held HLT must not trap the machine: stop wins here.
        if (stop_ev) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    men_d  = (state_d != ST_RUN);
    halt_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      adv_q   <= 1'b0;
      men_q   <= 1'b1;
      halt_q  <= 1'b0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      adv_q   <= adv_d;
      men_q   <= men_d;
      halt_q  <= halt_d;
      left_q  <= left_d;
    end
  end

  assign state       = state_q;
  assign adv_clk     = adv_q;
  assign manual_en   = men_q;
  assign halt        = halt_q;
  assign cycles_left = left_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: directed scenarios plus random button/HLT/reset
// traffic, all compared cycle by cycle against a behavioural model.
module tb_clock_sequencer;

  localparam int D  = 4;
  localparam int CW = 8;
  localparam int HL = D + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    btns = '0;  // 0 run, 1 stop, 2 step, 3 burst
  logic [CW-1:0] burst_n = '0;
  logic          hlt_instr = 1'b0;
  logic          manual_en, adv_clk, halt;
  logic [1:0]    state;
  logic [CW-1:0] cycles_left;

  clock_sequencer #(.DEBOUNCE_CYCLES(D), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_btn    (btns[0]),
    .stop_btn   (btns[1]),
    .step_btn   (btns[2]),
    .burst_btn  (btns[3]),
    .burst_n    (burst_n),
    .hlt_instr  (hlt_instr),
    .manual_en  (manual_en),
    .adv_clk    (adv_clk),
    .halt       (halt),
    .state      (state),
    .cycles_left(cycles_left)
  );

  always #5 clk = ~clk;

  // Reference model: a button level flips once the last D synchronized
  // samples all disagree with it; the event reaches the FSM two edges later.
  bit hist  [4][HL];
  bit lvl   [4];
  bit rose1 [4];
  bit rose2 [4];
  int m_state = 0;
  bit m_adv   = 0;
  int m_cl    = 0;
  int m_k     = 0;
  int m_n     = 0;

  task automatic model_step();
    bit ev [4];
    bit all_diff;
    bit rose_now;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < HL; i++) hist[b][i] = 0;
        lvl[b] = 0; rose1[b] = 0; rose2[b] = 0;
      end
      m_state = 0; m_adv = 0; m_cl = 0; m_k = 0; m_n = 0;
      return;
    end
    for (int b = 0; b < 4; b++) ev[b] = rose2[b];
    m_adv = 0;
    case (m_state)
      0: begin
        if (hlt_instr) m_state = 3;
        else if (ev[1]) m_state = 0;
        else if (ev[0]) m_state = 1;
        else if (ev[3]) begin
          if (burst_n != 0) begin
            m_state = 2; m_n = int'(burst_n); m_k = 0; m_adv = 1;
          end
        end else if (ev[2]) m_adv = 1;
      end
      1: begin
        if (hlt_instr) m_state = 3;
        else if (ev[1]) m_state = 0;
      end
      2: begin
        if (hlt_instr) m_state = 3;
        else if (ev[1]) m_state = 0;
        else begin
          m_k++;
          if (m_k == 2 * m_n) m_state = 0;
          else m_adv = (m_k % 2 == 0);
        end
      end
      default: begin
        if (ev[1]) m_state = 0;
      end
    endcase
    m_cl = (m_state == 2) ? m_n - (m_k + 1) / 2 : 0;
    for (int b = 0; b < 4; b++) begin
      for (int i = HL - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = btns[b];
      all_diff = 1;
      for (int i = 2; i < HL; i++) if (hist[b][i] == lvl[b]) all_diff = 0;
      rose_now = all_diff && !lvl[b];
      if (all_diff) lvl[b] = !lvl[b];
      rose2[b] = rose1[b];
      rose1[b] = rose_now;
    end
  endtask

  always @(posedge clk) model_step();

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_val("state", int'(state), m_state);
    check_val("manual_en", int'(manual_en), (m_state != 1) ? 1 : 0);
    check_val("halt", int'(halt), (m_state == 3) ? 1 : 0);
    check_val("adv_clk", int'(adv_clk), int'(m_adv));
    check_val("cycles_left", int'(cycles_left), m_cl);
    if (adv_clk) pulse_cnt++;
  endtask

  task automatic press(input int idx, input int hold);
    btns[idx] = 1'b1;
    repeat (hold) cycle();
    btns[idx] = 1'b0;
    repeat (12) cycle();
  endtask

  initial begin
    int p0;
    int pulse_edge;
    int npulse;
    int got_adv[$];
    int got_cl[$];
    int exp_adv[6] = '{1, 0, 1, 0, 1, 0};
    int exp_cl[6]  = '{3, 2, 2, 1, 1, 0};

    // Reset values
    repeat (2) cycle();
    rst = 1'b0;
    check_val("rst_state", int'(state), 0);
    check_val("rst_manual_en", int'(manual_en), 1);
    check_val("rst_adv_clk", int'(adv_clk), 0);
    check_val("rst_halt", int'(halt), 0);
    check_val("rst_cycles_left", int'(cycles_left), 0);
    repeat (3) cycle();

    // Single step: raw rise sampled at edge 0, pulse at edge 7
    p0 = pulse_cnt;
    pulse_edge = -1;
    btns[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (adv_clk) pulse_edge = i;
      if (i == 9) btns[2] = 1'b0;
    end
    check_val("step_pulses", pulse_cnt - p0, 1);
    check_val("step_edge", pulse_edge, 7);
    check_val("step_state", int'(state), 0);

    // Bounce never qualifies
    p0 = pulse_cnt;
    for (int i = 0; i < 12; i++) begin
      btns[2] = ((i / 2) % 2 == 0);
      cycle();
    end
    btns[2] = 1'b0;
    repeat (12) cycle();
    check_val("bounce_pulses", pulse_cnt - p0, 0);

    // Burst of 3
    burst_n = 8'd3;
    btns[3] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (state == 2'd2) begin
        got_adv.push_back(int'(adv_clk));
        got_cl.push_back(int'(cycles_left));
      end
      if (i == 9) btns[3] = 1'b0;
    end
    check_val("burst_len", got_adv.size(), 6);
    for (int i = 0; i < 6 && i < got_adv.size(); i++) begin
      check_val("burst_adv", got_adv[i], exp_adv[i]);
      check_val("burst_cl", got_cl[i], exp_cl[i]);
    end
    check_val("burst_end_state", int'(state), 0);

    // Run, then HLT, step ignored, stop exits
    press(0, 10);
    check_val("run_state", int'(state), 1);
    check_val("run_manual_en", int'(manual_en), 0);
    hlt_instr = 1'b1;
    cycle();
    hlt_instr = 1'b0;
    check_val("hlt_halt", int'(halt), 1);
    check_val("hlt_manual_en", int'(manual_en), 1);
    check_val("hlt_state", int'(state), 3);
    p0 = pulse_cnt;
    press(2, 10);
    check_val("halted_step_pulses", pulse_cnt - p0, 0);
    check_val("halted_state", int'(state), 3);
    press(1, 10);
    check_val("stop_state", int'(state), 0);
    check_val("stop_halt", int'(halt), 0);

    // Simultaneous run + step: run wins, no pulse
    p0 = pulse_cnt;
    btns[0] = 1'b1;
    btns[2] = 1'b1;
    repeat (10) cycle();
    btns[0] = 1'b0;
    btns[2] = 1'b0;
    repeat (12) cycle();
    check_val("simul_state", int'(state), 1);
    check_val("simul_pulses", pulse_cnt - p0, 0);
    press(1, 10);

    // Zero-length burst ignored
    burst_n = 8'd0;
    p0 = pulse_cnt;
    press(3, 10);
    check_val("burst0_state", int'(state), 0);
    check_val("burst0_pulses", pulse_cnt - p0, 0);

    // Reset mid-burst after the second pulse
    burst_n = 8'd5;
    npulse = 0;
    btns[3] = 1'b1;
    for (int i = 0; i < 40 && npulse < 2; i++) begin
      cycle();
      if (adv_clk) npulse++;
    end
    check_val("midburst_reached", npulse, 2);
    rst = 1'b1;
    btns[3] = 1'b0;
    cycle();
    rst = 1'b0;
    check_val("midrst_state", int'(state), 0);
    check_val("midrst_manual_en", int'(manual_en), 1);
    check_val("midrst_adv_clk", int'(adv_clk), 0);
    check_val("midrst_halt", int'(halt), 0);
    check_val("midrst_cycles_left", int'(cycles_left), 0);
    p0 = pulse_cnt;
    repeat (20) cycle();
    check_val("midrst_pulses", pulse_cnt - p0, 0);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 15) == 0) btns[b] = ~btns[b];
      hlt_instr = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 399) == 0);
      burst_n = CW'($urandom_range(0, 6));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_sequencer.md
# clock_sequencer

Run-control controller for the processor's clock module. Turns raw front-panel buttons (run, stop, step, burst) and the decoded HLT instruction into the `manual_en`, `adv_clk` and `halt` controls the clock module consumes. Supports free-running, single-step and N-cycle burst execution. Clocked by the free-running oscillator that also feeds the clock module's generator input.

## Interface

- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a button level is accepted (≥1)
- `COUNT_W`, 8: width of the burst length and remaining-cycle counter

- `clk` in 1: free-running generator clock
- `rst` in 1: synchronous, active-high reset
- `run_btn` in 1: raw, asynchronous; rising edge requests free-run
- `stop_btn` in 1: raw, asynchronous; rising edge returns to manual idle
- `step_btn` in 1: raw, asynchronous; rising edge requests one manual clock
- `burst_btn` in 1: raw, asynchronous; rising edge requests `burst_n` manual clocks
- `burst_n` in COUNT_W: burst length, sampled on the burst event
- `hlt_instr` in 1: synchronous, level; HLT decoded by the control logic
- `manual_en` out 1: 1 = clock module uses `adv_clk`; 0 = generator passes through
- `adv_clk` out 1: registered one-cycle pulse; one manual clock per pulse
- `halt` out 1: registered; gates the processor clock
- `state` out 2: current FSM state, for the front panel
- `cycles_left` out COUNT_W: remaining burst pulses

## Operation

- **Button conditioning**
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level flips only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the count.
  - A rising edge of the debounced level produces a one-cycle event (`run_ev`, `stop_ev`, `step_ev`, `burst_ev`).
  - Falling edges produce no event.
- **States**
  - IDLE = 0: `manual_en`=1, `halt`=0.
  - RUN = 1: `manual_en`=0, `halt`=0.
  - BURST = 2: `manual_en`=1, `halt`=0.
  - HALTED = 3: `manual_en`=1, `halt`=1.
- **Event priority within one cycle:** `rst` > `hlt_instr` > `stop_ev` > `run_ev` > `burst_ev` > `step_ev`. Lower-priority events in the same cycle are dropped, not queued.
- **IDLE**
  - `hlt_instr` → HALTED.
  - `run_ev` → RUN.
  - `burst_ev` with `burst_n`≠0 → BURST, loading `cycles_left`=`burst_n`.
  - `burst_ev` with `burst_n`=0 is ignored.
  - `step_ev` → `adv_clk`=1 for exactly the next cycle; state stays IDLE.
- **RUN**
  - `hlt_instr` → HALTED.
  - `stop_ev` → IDLE.
  - Step and burst events are ignored.
- **BURST**
  - `adv_clk` alternates high/low, starting high in the first cycle in BURST.
  - `cycles_left` decrements on each edge that ends a high cycle.
  - After the low cycle following the pulse that brings `cycles_left` to 0 → IDLE.
  - `stop_ev` → IDLE immediately, `cycles_left`=0, no further pulses.
  - `hlt_instr` → HALTED, `cycles_left`=0.
  - Run and step events are ignored.
- **HALTED**
  - Only `stop_ev` (→ IDLE) or `rst` leaves this state.
  - `hlt_instr` held high does not block `stop_ev` exit; it is level-sampled again next cycle.
  - All other events are ignored.
- **`adv_clk`** is 0 in RUN and HALTED, and on every state exit.
- **`cycles_left`** is 0 outside BURST.

## Timing

- **Reset values:** `state`=IDLE, `manual_en`=1, `adv_clk`=0, `halt`=0, `cycles_left`=0. Synchronizers and debouncers clear to level 0 with count 0.
- **Button latency:** let the raw rise first be sampled at edge 0.
  - The event is high in the cycle after edge 2+`DEBOUNCE_CYCLES`.
  - The FSM reacts at edge 3+`DEBOUNCE_CYCLES`.
  - The `adv_clk` pulse, or the new `manual_en`/state, is visible from that edge.
- **`hlt_instr`:** one-cycle latency. Sampled at edge k, `halt`=1 from edge k.
- **Burst length:** a burst of N occupies 2N cycles and yields exactly N one-cycle `adv_clk` pulses. Maximum N = 2^COUNT_W−1.
- **Reset mid-burst or mid-debounce:** all state is cleared at that edge and no pulse is emitted afterward. A button still held after reset must re-qualify from count 0.

## Structure

- Package `clock_ctrl_pkg` holds:
  - the state encoding constants (IDLE/RUN/BURST/HALTED);
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `btn_debounce` (synchronizer + debounce counter + rise-edge event) is instantiated four times.
- The FSM and burst counter live in `clock_sequencer`.

## Test plan

- Reset, then step: `step_btn` held 10 cycles with `DEBOUNCE_CYCLES`=4 → exactly one `adv_clk` pulse at edge 7 after first sample; `manual_en` stays 1; state stays 0.
- Bounce: `step_btn` toggles every 2 cycles for 12 cycles, then held low → no `adv_clk` pulse, no event.
- Burst: `burst_n`=3, burst press → `adv_clk` pattern 1,0,1,0,1,0; `cycles_left` 3→2→1→0; state 2→0 after 6 cycles.
- Run then HLT: run press → `manual_en`=0; `hlt_instr`=1 → next edge `halt`=1, `manual_en`=1, state=3; step press → no pulse; stop press → state 0, `halt`=0.
- Simultaneous events: `run_ev` and `step_ev` in the same cycle in IDLE → RUN, no `adv_clk`. `burst_n`=0 burst press → remains IDLE.
- Reset mid-burst: `burst_n`=5, assert `rst` after the second pulse → all outputs at reset values next cycle, no further pulses.
